mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer_if.sv | 32 +++
 rtl/mem_access_sequencer.sv | 117 +++++++++++
 tb/tb_mem_access_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request/handshake bundle between a requester, the RAM and mem_access_sequencer.
// master drives requests and MFC; slave is the sequencer's view.
interface mem_access_sequencer_if;
  logic       req;
  logic       is_store;
  logic [1:0] size;
  logic       sign_ext;
  logic [1:0] addr_low;
  logic       MFC;

  logic       MAR_Enable;
  logic       MDR_Enable;
  logic       MDR_Mux_select;
  logic       RAM_enable;
  logic [5:0] RAM_OpCode;
  logic       busy;
  logic       done;
  logic       trap;
  logic [2:0] tt;

  modport master (
    output req, is_store, size, sign_ext, addr_low, MFC,
    input  MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
    input  busy, done, trap, tt
  );

  modport slave (
    input  req, is_store, size, sign_ext, addr_low, MFC,
    output MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
    output busy, done, trap, tt
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences MAR load, RAM access and MDR capture for one load/store per request.
// Define MEM_TIMEOUT_EN to trap (tt=010) when MFC does not arrive within TIMEOUT_CYCLES.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   Clk,
  input  logic                   RESET,
  mem_access_sequencer_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] TRAP    = 3'd5;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       is_store_q;
  logic       sign_ext_q;
  logic [1:0] size_q;
  logic [1:0] addr_low_q;
  logic       req_illegal;
  logic       latched_illegal;
  logic       mfc_timeout;
  logic [2:0] trap_type;

  // Byte accesses are always aligned; size 11 is never a valid encoding.
  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] al);
    return (sz == 2'b11) ||
           ((sz == 2'b01) && al[0]) ||
           ((sz == 2'b10) && (al != 2'b00));
  endfunction

  assign req_illegal     = is_illegal(bus.size, bus.addr_low);
  assign latched_illegal = is_illegal(size_q, addr_low_q);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CountW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CountW-1:0] timeout_cnt;

  // Counts ACCESS cycles spent waiting; any other state leaves it cleared for the next entry.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      timeout_cnt <= '0;
    end else if (state != ACCESS) begin
      timeout_cnt <= '0;
    end else if (!bus.MFC) begin
      timeout_cnt <= timeout_cnt + CountW'(1);
    end
  end

  assign mfc_timeout = (32'(timeout_cnt) == (TIMEOUT_CYCLES - 1));
  assign trap_type   = latched_illegal ? 3'b001 : 3'b010;
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign mfc_timeout        = 1'b0;
  assign trap_type          = {2'b00, latched_illegal};
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          next_state = req_illegal ? TRAP : ADDR;
        end
      end
      ADDR:    next_state = ACCESS;
      ACCESS: begin
        if (bus.MFC) begin
          next_state = is_store_q ? DONE : CAPTURE;
        end else if (mfc_timeout) begin
          next_state = TRAP;
        end
      end
      CAPTURE: next_state = DONE;
      DONE:    next_state = IDLE;
      TRAP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance so a held req cannot disturb a transaction.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      sign_ext_q <= 1'b0;
      size_q     <= 2'b00;
      addr_low_q <= 2'b00;
    end else begin
      state <= next_state;
      if ((state == IDLE) && bus.req) begin
        is_store_q <= bus.is_store;
        sign_ext_q <= bus.sign_ext;
        size_q     <= bus.size;
        addr_low_q <= bus.addr_low;
      end
    end
  end

  assign bus.busy           = (state != IDLE);
  assign bus.MAR_Enable     = (state == ADDR);
  assign bus.RAM_enable     = (state == ACCESS);
  assign bus.RAM_OpCode     = (state == ACCESS) ? {is_store_q, 2'b00, sign_ext_q, size_q} : 6'b000000;
  assign bus.MDR_Enable     = (state == CAPTURE);
  assign bus.MDR_Mux_select = (state == CAPTURE);
  assign bus.done           = (state == DONE);
  assign bus.trap           = (state == TRAP);
  assign bus.tt             = (state == TRAP) ? trap_type : 3'b000;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: vector table plus hand-written
// sequences, with pulses checked against a scoreboard queue of expectations.
module tb_mem_access_sequencer;

  logic Clk;
  logic RESET;
  int   cyc;
  int   total;
  int   bad;

  mem_access_sequencer_if bus ();

  mem_access_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .Clk   (Clk),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic       st;
    logic [1:0] sz;
    logic       sx;
    logic [1:0] al;
    int         dly;
    logic       exp_trap;
    logic [2:0] exp_tt;
    logic [5:0] exp_op;
    int         exp_lat;
    int         exp_mar;
    int         exp_ram;
    int         exp_mdr;
  } vec_t;

  typedef struct {
    string      name;
    int         due;
    logic       trap;
    logic [2:0] tt;
    logic [5:0] op;
    int         mar;
    int         ram;
    int         mdr;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[12];

  int         mar_cnt;
  int         ram_cnt;
  int         mdr_cnt;
  int         glitch_cnt;
  logic [5:0] last_op;

  task automatic checkOutput(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input string n, input logic st, input logic [1:0] sz,
                              input logic sx, input logic [1:0] al, input int dly,
                              input logic tr, input logic [2:0] tt, input logic [5:0] op,
                              input int lat, input int mar, input int ram, input int mdr);
    vec_t v;
    v.name = n; v.st = st; v.sz = sz; v.sx = sx; v.al = al; v.dly = dly;
    v.exp_trap = tr; v.exp_tt = tt; v.exp_op = op; v.exp_lat = lat;
    v.exp_mar = mar; v.exp_ram = ram; v.exp_mdr = mdr;
    return v;
  endfunction

  // Monitor: tallies strobes between pulses and scores each done/trap pulse against the queue.
  always @(negedge Clk) begin
    if (!RESET) begin
      mar_cnt = 0; ram_cnt = 0; mdr_cnt = 0; glitch_cnt = 0; last_op = 6'b0;
    end else begin
      if (bus.MAR_Enable) mar_cnt++;
      if (bus.MDR_Enable) mdr_cnt++;
      if (bus.RAM_enable) begin
        ram_cnt++;
        last_op = bus.RAM_OpCode;
      end else if (bus.RAM_OpCode != 6'b0) begin
        glitch_cnt++;
      end
      if (bus.MDR_Mux_select != bus.MDR_Enable) glitch_cnt++;
      if (!bus.trap && (bus.tt != 3'b000)) glitch_cnt++;
      if (bus.done || bus.trap) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput({"when_", e.name}, cyc, e.due);
          checkOutput({"trap_", e.name}, bus.trap, e.trap);
          checkOutput({"done_", e.name}, bus.done, !e.trap);
          checkOutput({"tt_", e.name}, bus.tt, e.tt);
          checkOutput({"opcode_", e.name}, last_op, e.op);
          checkOutput({"mar_cycles_", e.name}, mar_cnt, e.mar);
          checkOutput({"ram_cycles_", e.name}, ram_cnt, e.ram);
          checkOutput({"mdr_cycles_", e.name}, mdr_cnt, e.mdr);
          checkOutput({"glitches_", e.name}, glitch_cnt, 0);
          checkOutput({"busy_at_pulse_", e.name}, bus.busy, 1);
        end
        mar_cnt = 0; ram_cnt = 0; mdr_cnt = 0; glitch_cnt = 0; last_op = 6'b0;
      end
    end
  end

  task automatic push_exp(input string n, input int acc, input vec_t v);
    exp_t e;
    e.name = n; e.due = acc + v.exp_lat - 1; e.trap = v.exp_trap; e.tt = v.exp_tt;
    e.op = v.exp_op; e.mar = v.exp_mar; e.ram = v.exp_ram; e.mdr = v.exp_mdr;
    sbq.push_back(e);
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge Clk);
    checkOutput({"pending_", n}, sbq.size(), 0);
    sbq.delete();
  endtask

  // One-cycle req; MFC is raised in cycle dly+2 (cycle 1 = ADDR after the accept edge).
  task automatic applyStimulus(input vec_t v);
    int acc;
    int span;
    @(negedge Clk);
    bus.req = 1'b1; bus.is_store = v.st; bus.size = v.sz;
    bus.sign_ext = v.sx; bus.addr_low = v.al; bus.MFC = 1'b0;
    acc = cyc + 1;
    push_exp(v.name, acc, v);
    span = ((v.exp_lat > v.dly + 2) ? v.exp_lat : v.dly + 2) + 1;
    for (int k = 1; k <= span; k++) begin
      @(negedge Clk);
      bus.req = 1'b0;
      bus.MFC = (k == v.dly + 2);
    end
    #1;
    drain(v.name);
    checkOutput({"idle_after_", v.name}, bus.busy, 0);
  endtask

  initial begin
    int acc;
    total = 0; bad = 0;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00;
    bus.sign_ext = 1'b0; bus.addr_low = 2'b00; bus.MFC = 1'b0;
    RESET = 1'b0;

    //            name        st  sz     sx  al     dly tr  tt      op         lat mar ram mdr
    vecs[0]  = mk("ld_word",  0, 2'b10, 0, 2'b00, 1,  0, 3'b000, 6'b000010, 5,  1,  2,  1);
    vecs[1]  = mk("st_sbyte", 1, 2'b00, 1, 2'b11, 0,  0, 3'b000, 6'b100100, 3,  1,  1,  0);
    vecs[2]  = mk("mis_half", 0, 2'b01, 0, 2'b01, 0,  1, 3'b001, 6'b000000, 1,  0,  0,  0);
    vecs[3]  = mk("ld_shalf", 0, 2'b01, 1, 2'b10, 0,  0, 3'b000, 6'b000101, 4,  1,  1,  1);
    vecs[4]  = mk("ld_byte",  0, 2'b00, 0, 2'b01, 2,  0, 3'b000, 6'b000000, 6,  1,  3,  1);
    vecs[5]  = mk("bad_size", 1, 2'b11, 0, 2'b00, 0,  1, 3'b001, 6'b000000, 1,  0,  0,  0);
    vecs[6]  = mk("mis_wst",  1, 2'b10, 0, 2'b10, 0,  1, 3'b001, 6'b000000, 1,  0,  0,  0);
    vecs[7]  = mk("st_word",  1, 2'b10, 0, 2'b00, 3,  0, 3'b000, 6'b100010, 6,  1,  4,  0);
    vecs[8]  = mk("st_half",  1, 2'b01, 1, 2'b10, 0,  0, 3'b000, 6'b100101, 3,  1,  1,  0);
`ifdef MEM_TIMEOUT_EN
    vecs[9]  = mk("ld_tmo",   0, 2'b10, 0, 2'b00, 40, 1, 3'b010, 6'b000010, 17, 1,  15, 0);
`else
    vecs[9]  = mk("ld_slow",  0, 2'b10, 0, 2'b00, 40, 0, 3'b000, 6'b000010, 44, 1,  41, 1);
`endif
    vecs[10] = mk("mis_wld",  0, 2'b10, 1, 2'b01, 0,  1, 3'b001, 6'b000000, 1,  0,  0,  0);
    vecs[11] = mk("st_byte",  1, 2'b00, 0, 2'b10, 0,  0, 3'b000, 6'b100000, 3,  1,  1,  0);

    // Reset state, with req held high to show nothing starts while in reset.
    #1;
    checkOutput("reset_outputs",
                {bus.busy, bus.done, bus.trap, bus.tt, bus.RAM_OpCode, bus.MAR_Enable,
                 bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable}, 0);
    bus.req = 1'b1;
    repeat (2) @(negedge Clk);
    checkOutput("reset_holds_idle", bus.busy, 0);
    bus.req = 1'b0;
    RESET = 1'b1;

    // MFC while idle must not start anything.
    @(negedge Clk);
    bus.MFC = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    checkOutput("mfc_idle_ignored", bus.busy, 0);
    bus.MFC = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // req held through a store with MFC stuck high: second store accepted in the IDLE cycle after DONE.
    @(negedge Clk);
    bus.req = 1'b1; bus.is_store = 1'b1; bus.size = 2'b00;
    bus.sign_ext = 1'b0; bus.addr_low = 2'b00; bus.MFC = 1'b1;
    acc = cyc + 1;
    push_exp("b2b_first", acc, mk("", 1, 2'b00, 0, 2'b00, 0, 0, 3'b000, 6'b100000, 3, 1, 1, 0));
    push_exp("b2b_second", acc + 4, mk("", 1, 2'b00, 0, 2'b00, 0, 0, 3'b000, 6'b100000, 3, 1, 1, 0));
    repeat (5) @(negedge Clk);
    bus.req = 1'b0;
    repeat (4) @(negedge Clk);
    bus.MFC = 1'b0;
    #1;
    checkOutput("b2b_no_third", bus.busy, 0);
    drain("b2b");

    // Reset mid-ACCESS with req held: transaction abandoned, no pulse, no restart.
    @(negedge Clk);
    bus.req = 1'b1; bus.is_store = 1'b0; bus.size = 2'b10;
    bus.sign_ext = 1'b0; bus.addr_low = 2'b00; bus.MFC = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    checkOutput("pre_reset_in_access", bus.RAM_enable, 1);
    #1;
    RESET = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                {bus.busy, bus.done, bus.trap, bus.tt, bus.RAM_OpCode, bus.MAR_Enable,
                 bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable}, 0);
    repeat (3) @(negedge Clk);
    checkOutput("midreset_held", bus.busy, 0);
    bus.req = 1'b0;
    RESET = 1'b1;
    repeat (4) @(negedge Clk);
    #1;
    checkOutput("post_reset_idle", bus.busy, 0);
    checkOutput("post_reset_no_pulse", sbq.size(), 0);
    applyStimulus(vecs[0]);
    applyStimulus(vecs[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time got %0t, expected finish before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
